// File: rtl/wb_xbar_rr.sv
// Wishbone B4 classic crossbar: m_count masters to s_count slaves with base/mask decode,
// a locking round-robin arbiter per slave and an err responder for unmapped addresses.
module wb_xbar_rr #(
    parameter int unsigned m_count   = 2,
    parameter int unsigned s_count   = 2,
    parameter int unsigned adr_width = 32,
    parameter int unsigned dat_width = 32,
    parameter int unsigned sel_width = dat_width / 8,
    parameter logic [s_count*adr_width-1:0] s_base = '0,
    parameter logic [s_count*adr_width-1:0] s_mask = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [m_count-1:0]             m_cyc,
    input  logic [m_count-1:0]             m_stb,
    input  logic [m_count-1:0]             m_we,
    input  logic [m_count*adr_width-1:0]   m_adr,
    input  logic [m_count*dat_width-1:0]   m_datwr,
    input  logic [m_count*sel_width-1:0]   m_sel,
    output logic [m_count*dat_width-1:0]   m_datrd,
    output logic [m_count-1:0]             m_ack,
    output logic [m_count-1:0]             m_rty,
    output logic [m_count-1:0]             m_err,
    output logic [s_count-1:0]             s_cyc,
    output logic [s_count-1:0]             s_stb,
    output logic [s_count-1:0]             s_we,
    output logic [s_count*adr_width-1:0]   s_adr,
    output logic [s_count*dat_width-1:0]   s_datwr,
    output logic [s_count*sel_width-1:0]   s_sel,
    input  logic [s_count*dat_width-1:0]   s_datrd,
    input  logic [s_count-1:0]             s_ack,
    input  logic [s_count-1:0]             s_rty,
    input  logic [s_count-1:0]             s_err
);

    localparam int unsigned mw = (m_count > 1) ? $clog2(m_count) : 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // m_onto[i] is one-hot on the lowest-index slave whose window contains master i's address
    logic [s_count-1:0] m_onto [m_count];
    logic [m_count-1:0] m_hit;
    logic [m_count-1:0] req [s_count];
    logic [m_count-1:0] unm_req;
    logic [m_count-1:0] unm_err_q;
    logic [m_count-1:0] unm_done_q;

    arb_state_t      state_q [s_count];
    arb_state_t      state_d [s_count];
    logic [mw-1:0]   gnt_q   [s_count];
    logic [mw-1:0]   gnt_d   [s_count];
    logic [mw-1:0]   last_q  [s_count];
    logic [mw-1:0]   last_d  [s_count];

    always_comb begin
        for (int unsigned i = 0; i < m_count; i++) begin
            m_onto[i] = '0;
            for (int unsigned k = s_count; k > 0; k--) begin
                if ((m_adr[i*adr_width +: adr_width] & s_mask[(k-1)*adr_width +: adr_width])
                        == s_base[(k-1)*adr_width +: adr_width]) begin
                    m_onto[i]        = '0;
                    m_onto[i][k-1]   = 1'b1;
                end
            end
            m_hit[i]   = |m_onto[i];
            unm_req[i] = m_cyc[i] & m_stb[i] & ~m_hit[i];
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < s_count; j++) begin
            for (int unsigned i = 0; i < m_count; i++) begin
                req[j][i] = m_cyc[i] & m_stb[i] & m_onto[i][j];
            end
        end
    end

    always_comb begin
        logic        found;
        int unsigned cand;
        found = 1'b0;
        cand  = 0;
        for (int unsigned j = 0; j < s_count; j++) begin
            state_d[j] = state_q[j];
            gnt_d[j]   = gnt_q[j];
            last_d[j]  = last_q[j];
            found      = 1'b0;
            case (state_q[j])
                ARB_IDLE: begin
                    // search order starts just after the previous winner and wraps
                    for (int unsigned k = 1; k <= m_count; k++) begin
                        cand = (32'(last_q[j]) + k) % m_count;
                        for (int unsigned i = 0; i < m_count; i++) begin
                            if (!found && i == cand && req[j][i]) begin
                                found      = 1'b1;
                                gnt_d[j]   = mw'(i);
                                last_d[j]  = mw'(i);
                                state_d[j] = ARB_BUSY;
                            end
                        end
                    end
                end
                ARB_BUSY: begin
                    for (int unsigned i = 0; i < m_count; i++) begin
                        if (gnt_q[j] == mw'(i) &&
                                (!m_cyc[i] || (m_stb[i] && !m_onto[i][j]))) begin
                            state_d[j] = ARB_IDLE;
                        end
                    end
                end
                default: state_d[j] = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned j = 0; j < s_count; j++) begin
            if (reset) begin
                state_q[j] <= ARB_IDLE;
                gnt_q[j]   <= '0;
                last_q[j]  <= mw'(m_count - 1);
            end else begin
                state_q[j] <= state_d[j];
                gnt_q[j]   <= gnt_d[j];
                last_q[j]  <= last_d[j];
            end
        end
    end

    // one err pulse per unmapped strobe; done stays set until the strobe is withdrawn
    always_ff @(posedge clock) begin
        if (reset) begin
            unm_err_q  <= '0;
            unm_done_q <= '0;
        end else begin
            unm_err_q  <= unm_req & ~unm_err_q & ~unm_done_q;
            unm_done_q <= (unm_err_q | unm_done_q) & unm_req;
        end
    end

    always_comb begin
        s_cyc   = '0;
        s_stb   = '0;
        s_we    = '0;
        s_adr   = '0;
        s_datwr = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_rty   = '0;
        m_err   = '0;
        m_datrd = '0;
        for (int unsigned j = 0; j < s_count; j++) begin
            for (int unsigned i = 0; i < m_count; i++) begin
                if (state_q[j] == ARB_BUSY && gnt_q[j] == mw'(i)) begin
                    s_cyc[j] = m_cyc[i];
                    s_stb[j] = m_stb[i];
                    s_we[j]  = m_we[i];
                    s_adr[j*adr_width +: adr_width]   = m_adr[i*adr_width +: adr_width];
                    s_datwr[j*dat_width +: dat_width] = m_datwr[i*dat_width +: dat_width];
                    s_sel[j*sel_width +: sel_width]   = m_sel[i*sel_width +: sel_width];
                    m_ack[i] = m_ack[i] | s_ack[j];
                    m_rty[i] = m_rty[i] | s_rty[j];
                    m_err[i] = m_err[i] | s_err[j];
                    m_datrd[i*dat_width +: dat_width] =
                        m_datrd[i*dat_width +: dat_width] | s_datrd[j*dat_width +: dat_width];
                end
            end
        end
        m_err = m_err | unm_err_q;
    end

endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed and random checks of wb_xbar_rr (2 masters, 2 slaves) against a transaction-level
// model: slave 0 at 0x0xxx_xxxx, slave 1 at 0x1xxx_xxxx, everything else unmapped.
module tb_wb_xbar_rr;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_adr, m_datwr;
    logic [7:0]  m_sel;
    logic [63:0] m_datrd;
    logic [1:0]  m_ack, m_rty, m_err;
    logic [1:0]  s_cyc, s_stb, s_we;
    logic [63:0] s_adr, s_datwr;
    logic [7:0]  s_sel;
    logic [63:0] s_datrd;
    logic [1:0]  s_ack, s_rty, s_err;

    int tests  = 0;
    int failed = 0;

    // model: owner per slave (-1 when free), previous winner, unmapped err pulse state
    int         owner [2];
    int         last  [2];
    logic [1:0] uerr;
    logic [1:0] udone;

    wb_xbar_rr #(
        .m_count  (2),
        .s_count  (2),
        .adr_width(32),
        .dat_width(32),
        .sel_width(4),
        .s_base   ({32'h1000_0000, 32'h0000_0000}),
        .s_mask   ({32'hF000_0000, 32'hF000_0000})
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_we   (m_we),
        .m_adr  (m_adr),
        .m_datwr(m_datwr),
        .m_sel  (m_sel),
        .m_datrd(m_datrd),
        .m_ack  (m_ack),
        .m_rty  (m_rty),
        .m_err  (m_err),
        .s_cyc  (s_cyc),
        .s_stb  (s_stb),
        .s_we   (s_we),
        .s_adr  (s_adr),
        .s_datwr(s_datwr),
        .s_sel  (s_sel),
        .s_datrd(s_datrd),
        .s_ack  (s_ack),
        .s_rty  (s_rty),
        .s_err  (s_err)
    );

    always #5 clock = ~clock;

    function automatic int tgt(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        if (a[31:28] == 4'h1) return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (i == 0) begin
            m_cyc[0] = cyc; m_stb[0] = stb; m_we[0] = we;
            m_adr[31:0] = adr; m_datwr[31:0] = dat; m_sel[3:0] = 4'hF;
        end else begin
            m_cyc[1] = cyc; m_stb[1] = stb; m_we[1] = we;
            m_adr[63:32] = adr; m_datwr[63:32] = dat; m_sel[7:4] = 4'hF;
        end
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_datwr = '0; m_sel = '0;
        s_datrd = '0; s_ack = '0; s_rty = '0; s_err = '0;
    endtask

    task automatic model_update();
        logic [1:0] u;
        if (reset) begin
            owner[0] = -1; owner[1] = -1;
            last[0]  = 1;  last[1]  = 1;
            uerr = '0; udone = '0;
            return;
        end
        for (int j = 0; j < 2; j++) begin
            if (owner[j] >= 0) begin
                for (int i = 0; i < 2; i++)
                    if (owner[j] == i &&
                        (!m_cyc[i] || (m_stb[i] && tgt(m_adr[i*32 +: 32]) != j)))
                        owner[j] = -1;
            end else begin
                for (int k = 1; k <= 2; k++)
                    for (int i = 0; i < 2; i++)
                        if (owner[j] < 0 && i == (last[j] + k) % 2 && m_cyc[i] && m_stb[i] &&
                            tgt(m_adr[i*32 +: 32]) == j) begin
                            owner[j] = i;
                            last[j]  = i;
                        end
            end
        end
        for (int i = 0; i < 2; i++) u[i] = m_cyc[i] & m_stb[i] & (tgt(m_adr[i*32 +: 32]) < 0);
        udone = (uerr | udone) & u;
        uerr  = u & ~uerr & ~(udone & ~u) & ~((uerr | udone) & ~uerr & u);
    endtask

    task automatic clk();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic settle_check();
        logic [1:0]  e_cyc, e_stb, e_we, e_ack, e_rty, e_err;
        logic [63:0] e_adr, e_dat, e_rd;
        logic [7:0]  e_sel;
        #2;
        e_cyc = '0; e_stb = '0; e_we = '0; e_ack = '0; e_rty = '0; e_err = '0;
        e_adr = '0; e_dat = '0; e_rd = '0; e_sel = '0;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 2; i++)
                if (owner[j] == i) begin
                    e_cyc[j] = m_cyc[i];
                    e_stb[j] = m_stb[i];
                    e_we[j]  = m_we[i];
                    e_adr[j*32 +: 32] = m_adr[i*32 +: 32];
                    e_dat[j*32 +: 32] = m_datwr[i*32 +: 32];
                    e_sel[j*4 +: 4]   = m_sel[i*4 +: 4];
                    e_ack[i] = e_ack[i] | s_ack[j];
                    e_rty[i] = e_rty[i] | s_rty[j];
                    e_err[i] = e_err[i] | s_err[j];
                    e_rd[i*32 +: 32] = s_datrd[j*32 +: 32];
                end
        e_err = e_err | uerr;
        chk("s_cyc",   64'(s_cyc),   64'(e_cyc));
        chk("s_stb",   64'(s_stb),   64'(e_stb));
        chk("s_we",    64'(s_we),    64'(e_we));
        chk("s_adr",   s_adr,        e_adr);
        chk("s_datwr", s_datwr,      e_dat);
        chk("s_sel",   64'(s_sel),   64'(e_sel));
        chk("m_ack",   64'(m_ack),   64'(e_ack));
        chk("m_rty",   64'(m_rty),   64'(e_rty));
        chk("m_err",   64'(m_err),   64'(e_err));
        chk("m_datrd", m_datrd,      e_rd);
    endtask

    initial begin
        logic [31:0] exp_adr;
        int          r;
        clear_inputs();
        reset = 1'b1;
        clk();
        clk();
        reset = 1'b0;
        settle_check();
        chk("reset_s_cyc", 64'(s_cyc), 64'd0);
        chk("reset_m_err", 64'(m_err), 64'd0);

        // single write to slave 0
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        settle_check();
        chk("wr_stb_before", 64'(s_stb[0]), 64'd0);
        clk();
        settle_check();
        chk("wr_stb_after", 64'(s_stb[0]), 64'd1);
        chk("wr_datwr", 64'(s_datwr[31:0]), 64'hDEAD_BEEF);
        s_ack = 2'b01;
        settle_check();
        chk("wr_ack", 64'(m_ack), 64'd1);
        clk();
        clear_inputs();
        settle_check();
        clk();
        settle_check();

        // contention on slave 1: strict alternation starting with m0
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
        settle_check();
        clk();
        for (int t = 0; t < 6; t++) begin
            exp_adr = (t % 2 == 0) ? 32'h1000_0000 : 32'h1000_0004;
            s_ack = 2'b10;
            settle_check();
            chk("cont_adr", 64'(s_adr[63:32]), 64'(exp_adr));
            chk("cont_ack", 64'(m_ack), (t % 2 == 0) ? 64'd1 : 64'd2);
            clk();
            s_ack = '0;
            set_m(t % 2, 1'b0, 1'b0, 1'b0, exp_adr, 32'h0);
            settle_check();
            clk();
            set_m(t % 2, 1'b1, 1'b1, 1'b0, exp_adr, 32'h0);
            settle_check();
            clk();
        end
        clear_inputs();
        settle_check();
        clk();
        settle_check();
        clk();

        // concurrent grants, no datrd cross-routing
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000_0020, 32'h0);
        s_datrd = {32'h2222_2222, 32'h1111_1111};
        settle_check();
        clk();
        s_ack = 2'b11;
        settle_check();
        chk("conc_cyc", 64'(s_cyc), 64'd3);
        chk("conc_datrd", m_datrd, {32'h2222_2222, 32'h1111_1111});
        chk("conc_ack", 64'(m_ack), 64'd3);
        clk();
        clear_inputs();
        settle_check();
        clk();
        settle_check();
        clk();

        // lock: m0 keeps cyc across stb gaps, m1 waits on slave 0
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0);
        settle_check();
        clk();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
        for (int n = 0; n < 4; n++) begin
            set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0);
            s_ack = 2'b01;
            settle_check();
            chk("lock_owner", 64'(s_adr[31:0]), 64'h40);
            clk();
            s_ack = '0;
            set_m(0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0);
            settle_check();
            chk("lock_gap", 64'({s_cyc[0], s_adr[31:0]}), 64'h1_0000_0040);
            clk();
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        settle_check();
        clk();
        settle_check();
        chk("lock_idle", 64'(s_cyc[0]), 64'd0);
        clk();
        settle_check();
        chk("lock_handover", 64'({s_cyc[0], s_adr[31:0]}), 64'h1_0000_0044);
        clear_inputs();
        clk();
        settle_check();
        clk();

        // unmapped read: single err pulse, no slave driven
        set_m(1, 1'b1, 1'b1, 1'b0, 32'hF000_0000, 32'h0);
        settle_check();
        chk("unm_pre", 64'(m_err), 64'd0);
        clk();
        settle_check();
        chk("unm_pulse", 64'({s_cyc, m_err}), 64'b00_10);
        clk();
        settle_check();
        chk("unm_once", 64'(m_err), 64'd0);
        clear_inputs();
        clk();
        settle_check();

        // reset while slave 0 is busy
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        settle_check();
        clk();
        settle_check();
        chk("rst_busy", 64'(s_cyc[0]), 64'd1);
        reset = 1'b1;
        clk();
        reset = 1'b0;
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0084, 32'h0);
        s_ack = 2'b01;
        settle_check();
        chk("rst_drop", 64'({s_cyc, m_ack}), 64'd0);
        s_ack = '0;
        clk();
        settle_check();
        chk("rst_first", 64'(s_adr[31:0]), 64'h80);
        clear_inputs();
        clk();

        // random traffic against the model
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 4) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 2) != 0);
                m_we[i]  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 3) begin
                    r = $urandom_range(0, 4);
                    m_adr[i*32 +: 32] = ((r < 2) ? 32'h0000_0000 : (r < 4) ? 32'h1000_0000 : 32'hF000_0000)
                                        | ($urandom & 32'h0FFF_FFFC);
                end
                m_datwr[i*32 +: 32] = $urandom;
                m_sel[i*4 +: 4]     = 4'($urandom_range(0, 15));
                s_datrd[i*32 +: 32] = $urandom;
                s_ack[i] = ($urandom_range(0, 2) == 0);
                s_rty[i] = ($urandom_range(0, 7) == 0);
                s_err[i] = ($urandom_range(0, 7) == 0);
            end
            settle_check();
            clk();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
